// File: rtl/fwb_master_checker.sv
// Passive Wishbone pipelined-bus master protocol checker: counts requests and
// responses of the current bus cycle and latches sticky per-rule violation flags.
module fwb_master_checker #(
  parameter int AW                   = 30,
  parameter int DW                   = 32,
  parameter int F_LGDEPTH            = 4,
  parameter int F_MAX_STALL          = 0,
  parameter int F_MAX_ACK_DELAY      = 0,
  parameter int F_OPT_RMW_BUS_OPTION = 0,
  parameter int F_OPT_DISCONTINUOUS  = 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_wb_cyc,
  input  logic                 i_wb_stb,
  input  logic                 i_wb_we,
  input  logic [AW-1:0]        i_wb_addr,
  input  logic [DW-1:0]        i_wb_data,
  input  logic [DW/8-1:0]      i_wb_sel,
  input  logic                 i_wb_ack,
  input  logic                 i_wb_stall,
  input  logic                 i_wb_err,
  input  logic [DW-1:0]        i_wb_idata,
  output logic [F_LGDEPTH-1:0] f_nreqs,
  output logic [F_LGDEPTH-1:0] f_nacks,
  output logic [F_LGDEPTH-1:0] f_outstanding,
  output logic [8:0]           o_violation,
  output logic                 o_fault
);

  localparam int SW = DW / 8;
  localparam int TW = 16;

  logic                 req, resp;
  logic [F_LGDEPTH-1:0] nreqs_q, nreqs_d, nacks_q, nacks_d, outst_q, outst_d;
  logic [TW-1:0]        stallCnt_q, stallCnt_d, ackDly_q, ackDly_d;
  logic                 stalled_q, stalled_d;
  logic                 prevWe_q, prevWe_d;
  logic [AW-1:0]        prevAddr_q, prevAddr_d;
  logic [DW-1:0]        prevData_q, prevData_d;
  logic [SW-1:0]        prevSel_q, prevSel_d;
  logic                 firstSeen_q, firstSeen_d, firstWe_q, firstWe_d;
  logic                 stbSeen_q, stbSeen_d, stbFell_q, stbFell_d;
  logic                 errPrev_q, errPrev_d;
  logic [8:0]           viol_q, viol_d, vNow;

  assign req  = i_wb_cyc & i_wb_stb & ~i_wb_stall;
  assign resp = i_wb_cyc & (i_wb_ack | i_wb_err);

  always_comb begin
    nreqs_d     = '0;
    nacks_d     = '0;
    outst_d     = '0;
    stallCnt_d  = '0;
    ackDly_d    = '0;
    stalled_d   = i_wb_cyc & i_wb_stb & i_wb_stall;
    prevWe_d    = i_wb_we;
    prevAddr_d  = i_wb_addr;
    prevData_d  = i_wb_data;
    prevSel_d   = i_wb_sel;
    firstSeen_d = i_wb_cyc & (firstSeen_q | req);
    firstWe_d   = (req & ~firstSeen_q) ? i_wb_we : firstWe_q;
    stbSeen_d   = i_wb_cyc & (stbSeen_q | i_wb_stb);
    stbFell_d   = i_wb_cyc & (stbFell_q | (stbSeen_q & ~i_wb_stb));
    errPrev_d   = i_wb_cyc & i_wb_err;
    vNow        = '0;

    // Counters live only inside a bus cycle; dropping cyc aborts and clears them.
    if (i_wb_cyc) begin
      nreqs_d = nreqs_q;
      nacks_d = nacks_q;
      if (req && nreqs_q != '1)
        nreqs_d = nreqs_q + 1'b1;
      if (resp && nacks_q != '1)
        nacks_d = nacks_q + 1'b1;
      outst_d = nreqs_d - nacks_d;
      if (stalled_d)
        stallCnt_d = (stallCnt_q == '1) ? stallCnt_q : stallCnt_q + 1'b1;
      if (outst_q != '0 && !resp)
        ackDly_d = (ackDly_q == '1) ? ackDly_q : ackDly_q + 1'b1;
    end

    // Read data is never checked; the zero term only keeps the port referenced.
    vNow[0] = (i_wb_stb & ~i_wb_cyc) | (1'b0 & (^i_wb_idata));
    vNow[1] = stalled_q & i_wb_cyc &
              (~i_wb_stb | (i_wb_we != prevWe_q) | (i_wb_addr != prevAddr_q) |
               (i_wb_data != prevData_q) | (i_wb_sel != prevSel_q));
    vNow[2] = resp & (outst_q == '0);
    vNow[3] = (F_MAX_STALL != 0) && ({16'd0, stallCnt_d} > 32'(F_MAX_STALL));
    vNow[4] = (F_MAX_ACK_DELAY != 0) && ({16'd0, ackDly_d} > 32'(F_MAX_ACK_DELAY));
    vNow[5] = (F_OPT_RMW_BUS_OPTION == 0) && req && firstSeen_q && (i_wb_we != firstWe_q);
    vNow[6] = (F_OPT_DISCONTINUOUS == 0) && i_wb_cyc && i_wb_stb && stbFell_q;
    vNow[7] = req & (nreqs_q == '1);
    vNow[8] = errPrev_q & i_wb_cyc;

    viol_d = viol_q | vNow;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      nreqs_q     <= '0;
      nacks_q     <= '0;
      outst_q     <= '0;
      stallCnt_q  <= '0;
      ackDly_q    <= '0;
      stalled_q   <= 1'b0;
      prevWe_q    <= 1'b0;
      prevAddr_q  <= '0;
      prevData_q  <= '0;
      prevSel_q   <= '0;
      firstSeen_q <= 1'b0;
      firstWe_q   <= 1'b0;
      stbSeen_q   <= 1'b0;
      stbFell_q   <= 1'b0;
      errPrev_q   <= 1'b0;
      viol_q      <= '0;
    end else begin
      nreqs_q     <= nreqs_d;
      nacks_q     <= nacks_d;
      outst_q     <= outst_d;
      stallCnt_q  <= stallCnt_d;
      ackDly_q    <= ackDly_d;
      stalled_q   <= stalled_d;
      prevWe_q    <= prevWe_d;
      prevAddr_q  <= prevAddr_d;
      prevData_q  <= prevData_d;
      prevSel_q   <= prevSel_d;
      firstSeen_q <= firstSeen_d;
      firstWe_q   <= firstWe_d;
      stbSeen_q   <= stbSeen_d;
      stbFell_q   <= stbFell_d;
      errPrev_q   <= errPrev_d;
      viol_q      <= viol_d;
    end
  end

  assign f_nreqs       = nreqs_q;
  assign f_nacks       = nacks_q;
  assign f_outstanding = outst_q;
  assign o_violation   = viol_q;
  assign o_fault       = |viol_q;

endmodule

// File: tb/tb_fwb_master_checker.sv
// Directed bench: one checker with a 2-clock stall limit, one with the limit disabled,
// both watching the same stimulus.
module tb_fwb_master_checker;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_wb_cyc, i_wb_stb, i_wb_we, i_wb_ack, i_wb_stall, i_wb_err;
  logic [29:0] i_wb_addr;
  logic [31:0] i_wb_data, i_wb_idata;
  logic [3:0]  i_wb_sel;

  logic [3:0]  nreqsA, nacksA, outstA, nreqsB, nacksB, outstB;
  logic [8:0]  violA, violB;
  logic        faultA, faultB;

  int compared   = 0;
  int mismatched = 0;

  always #5 i_clk = ~i_clk;

  fwb_master_checker #(.F_MAX_STALL(2)) dutA (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
    .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data), .i_wb_sel(i_wb_sel),
    .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall), .i_wb_err(i_wb_err),
    .i_wb_idata(i_wb_idata),
    .f_nreqs(nreqsA), .f_nacks(nacksA), .f_outstanding(outstA),
    .o_violation(violA), .o_fault(faultA)
  );

  fwb_master_checker #(.F_MAX_STALL(0)) dutB (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
    .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data), .i_wb_sel(i_wb_sel),
    .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall), .i_wb_err(i_wb_err),
    .i_wb_idata(i_wb_idata),
    .f_nreqs(nreqsB), .f_nacks(nacksB), .f_outstanding(outstB),
    .o_violation(violB), .o_fault(faultB)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 2 time units after the edge.
  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  task automatic idle();
    i_wb_cyc = 0; i_wb_stb = 0; i_wb_we = 0; i_wb_ack = 0;
    i_wb_stall = 0; i_wb_err = 0;
  endtask

  task automatic pulseReset();
    #1 i_reset_n = 0;
    #1 i_reset_n = 1;
  endtask

  initial begin
    i_reset_n = 0;
    idle();
    i_wb_addr = '0; i_wb_data = 32'h1234_5678; i_wb_sel = 4'hF; i_wb_idata = 32'hCAFE_F00D;
    #3;
    check("reset_nreqs", 32'(nreqsA), 0);
    check("reset_outst", 32'(outstA), 0);
    check("reset_viol",  32'(violA), 0);
    check("reset_fault", 32'(faultA), 0);
    #4 i_reset_n = 1;
    tick();

    // Single read: one request, ack next clock, then cyc drops.
    i_wb_cyc = 1; i_wb_stb = 1; i_wb_addr = 30'd5;
    tick();
    check("rd_nreqs1", 32'(nreqsA), 1);
    check("rd_outst1", 32'(outstA), 1);
    i_wb_stb = 0; i_wb_ack = 1;
    tick();
    check("rd_nreqs2", 32'(nreqsA), 1);
    check("rd_nacks2", 32'(nacksA), 1);
    check("rd_outst2", 32'(outstA), 0);
    idle();
    tick();
    check("rd_nreqs3", 32'(nreqsA), 0);
    check("rd_nacks3", 32'(nacksA), 0);
    check("rd_fault3", 32'(faultA), 0);

    // Pipelined: two requests back to back, ack overlapping the second request.
    i_wb_cyc = 1; i_wb_stb = 1; i_wb_addr = 30'd8;
    tick();
    i_wb_addr = 30'd9; i_wb_ack = 1;
    tick();
    check("pipe_nreqs", 32'(nreqsA), 2);
    check("pipe_nacks", 32'(nacksA), 1);
    check("pipe_outst", 32'(outstA), 1);
    i_wb_stb = 0;
    tick();
    check("pipe_outst_end", 32'(outstA), 0);
    check("pipe_viol", 32'(violA), 0);
    idle();
    tick();

    // Error response with cyc dropped immediately is legal.
    i_wb_cyc = 1; i_wb_stb = 1;
    tick();
    i_wb_stb = 0; i_wb_err = 1;
    tick();
    idle();
    tick();
    check("err_drop_viol", 32'(violA), 0);

    // Error response with cyc held one more clock.
    i_wb_cyc = 1; i_wb_stb = 1;
    tick();
    i_wb_stb = 0; i_wb_err = 1;
    tick();
    i_wb_err = 0;
    tick();
    check("err_hold_viol", 32'(violA), 32'h100);
    idle();
    tick();
    check("err_sticky", 32'(violA), 32'h100);
    pulseReset();
    check("err_reset_viol", 32'(violA), 0);
    tick();

    // Spurious ack with nothing outstanding.
    i_wb_cyc = 1; i_wb_ack = 1;
    tick();
    check("spur_viol", 32'(violA), 32'h004);
    check("spur_fault", 32'(faultA), 1);
    idle();
    tick();
    pulseReset();
    tick();

    // Stalled request whose address changes on the second stalled clock.
    i_wb_cyc = 1; i_wb_stb = 1; i_wb_stall = 1; i_wb_addr = 30'd10;
    tick();
    i_wb_addr = 30'd11;
    tick();
    check("hold_viol_early", 32'(violB), 32'h002);
    tick();
    check("hold_violB", 32'(violB), 32'h002);
    check("hold_faultB", 32'(faultB), 1);
    check("hold_violA", 32'(violA), 32'h00A);
    idle();
    tick();
    check("hold_sticky", 32'(violB), 32'h002);
    pulseReset();
    tick();

    // Stall timeout: limit 2 on dutA, disabled on dutB.
    i_wb_cyc = 1; i_wb_stb = 1; i_wb_stall = 1; i_wb_addr = 30'd20;
    tick();
    tick();
    check("stall2_violA", 32'(violA), 0);
    tick();
    tick();
    check("stall4_violA", 32'(violA), 32'h008);
    check("stall4_violB", 32'(violB), 0);
    idle();
    tick();
    pulseReset();
    tick();

    // stb without cyc, then a 3-request burst, then async reset between edges.
    i_wb_stb = 1;
    tick();
    check("stbnocyc_viol", 32'(violA), 32'h001);
    i_wb_cyc = 1;
    tick();
    tick();
    tick();
    check("burst_nreqs", 32'(nreqsA), 3);
    check("burst_outst", 32'(outstA), 3);
    #1 i_reset_n = 0;
    #1;
    check("arst_nreqs", 32'(nreqsA), 0);
    check("arst_outst", 32'(outstA), 0);
    check("arst_viol",  32'(violA), 0);
    check("arst_fault", 32'(faultA), 0);
    idle();
    #1 i_reset_n = 1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
